fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Keeps at most one instruction-bus request outstanding and tracks the fetch PC.
// A redirect can arrive while a request is still pending. In that case the
// request is kept on the bus until it completes, and its response is thrown away.
// An instruction that returns during a stall is buffered until the stall clears.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        i_wait,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] pc_out
);

  // RUN : the request for r_pc is outstanding
  // DROP: a stale request (r_dropAddr) is outstanding and its data will be ignored
  // HOLD: a fetched word is parked in r_holdInstr while decode is stalled
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    HOLD = 2'd2
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_nextState;
  logic [63:0] r_pc;
  logic [63:0] r_dropAddr;
  logic [31:0] r_holdInstr;
  logic [63:0] w_redirectAligned;
  logic [63:0] w_pcPlus4;

  // Redirect targets are always word aligned before they enter the PC.
  assign w_redirectAligned = {redirect_pc[63:2], 2'b00};
  assign w_pcPlus4         = r_pc + 64'd4;

  // Register the state. Reset returns the FSM to RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Select the next state. A redirect has priority over a stall, and a stall
  // has priority over a normal advance.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_nextState = iresp_data_ok ? RUN : DROP;
        end else if (iresp_data_ok && stallF) begin
          w_nextState = HOLD;
        end
      end
      DROP: begin
        if (iresp_data_ok) begin
          w_nextState = RUN;
        end
      end
      HOLD: begin
        if (redirect_valid || !stallF) begin
          w_nextState = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
  end

  // Update the PC, the address of the abandoned request, and the buffered
  // instruction, using the same priority as the next-state logic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc        <= RESET_PC;
      r_dropAddr  <= 64'd0;
      r_holdInstr <= 32'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (redirect_valid) begin
            r_pc <= w_redirectAligned;
            if (!iresp_data_ok) begin
              r_dropAddr <= r_pc;
            end
          end else if (iresp_data_ok) begin
            if (stallF) begin
              r_holdInstr <= iresp_data;
            end else begin
              r_pc <= w_pcPlus4;
            end
          end
        end
        DROP: begin
          if (redirect_valid) begin
            r_pc <= w_redirectAligned;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_pc <= w_redirectAligned;
          end else if (!stallF) begin
            r_pc <= w_pcPlus4;
          end
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // Drive the outputs from the state. They are gated by resetn, so a reset
  // pulse quiets the bus at once and the first request goes out as soon as
  // reset is released.
  always_comb begin
    ireq_valid  = 1'b0;
    ireq_addr   = r_pc;
    i_wait      = 1'b1;
    instr_valid = 1'b0;
    instr       = iresp_data;
    pc_out      = r_pc;
    if (resetn) begin
      case (r_state)
        RUN: begin
          ireq_valid  = 1'b1;
          i_wait      = ~iresp_data_ok;
          instr_valid = iresp_data_ok & ~redirect_valid;
        end
        DROP: begin
          ireq_valid = 1'b1;
          ireq_addr  = r_dropAddr;
        end
        HOLD: begin
          i_wait      = 1'b0;
          instr_valid = ~redirect_valid;
          instr       = r_holdInstr;
        end
        default: begin
          ireq_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// Inputs change on the falling clock edge. Outputs are checked 1 ns later,
// well before the next rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        resetn;
  logic        stallF;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        i_wait;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] pc_out;

  int checkCount;
  int errorCount;

  fetch_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .stallF        (stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .i_wait        (i_wait),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_out        (pc_out)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  // Wait for the next falling edge, drive one cycle of inputs, then let the
  // combinational outputs settle.
  task automatic applyStimulus(input logic stall, input logic rv, input logic [63:0] rpc,
                               input logic dok, input logic [31:0] data);
    @(negedge clk);
    stallF         = stall;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data_ok  = dok;
    iresp_data     = data;
    #1;
  endtask

  initial begin
    checkCount     = 0;
    errorCount     = 0;
    resetn         = 1'b0;
    stallF         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;

    // Outputs while reset is held.
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    checkOutput("rst_instr_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_i_wait", 64'(i_wait), 64'd1);

    // Release reset. The first request goes out at once, and data arrives
    // on the fourth cycle.
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkOutput("first_req_valid", 64'(ireq_valid), 64'd1);
    checkOutput("first_req_addr", ireq_addr, 64'h8000_0000);
    checkOutput("wait_c1", 64'(i_wait), 64'd1);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("wait_c2", 64'(i_wait), 64'd1);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("wait_c3", 64'(i_wait), 64'd1);
    applyStimulus(0, 0, 64'd0, 1, 32'h0000_0013);
    checkOutput("first_instr_valid", 64'(instr_valid), 64'd1);
    checkOutput("first_instr", 64'(instr), 64'h13);
    checkOutput("first_pc_out", pc_out, 64'h8000_0000);
    checkOutput("first_wait_low", 64'(i_wait), 64'd0);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("second_req_addr", ireq_addr, 64'h8000_0004);

    // Data arrives while decode is stalled: the word is buffered in HOLD.
    applyStimulus(1, 0, 64'd0, 1, 32'hAAAA_0001);
    checkOutput("stall_data_valid", 64'(instr_valid), 64'd1);
    checkOutput("stall_data_pc", pc_out, 64'h8000_0004);
    applyStimulus(1, 0, 64'd0, 0, 32'd0);
    checkOutput("hold_req_valid", 64'(ireq_valid), 64'd0);
    checkOutput("hold_instr_valid", 64'(instr_valid), 64'd1);
    checkOutput("hold_instr", 64'(instr), 64'hAAAA_0001);
    checkOutput("hold_wait", 64'(i_wait), 64'd0);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("hold_release_pc", pc_out, 64'h8000_0004);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("after_hold_addr", ireq_addr, 64'h8000_0008);

    // Redirect while a request is pending: the stale request (0x8000_0008)
    // stays on the bus until its data returns.
    applyStimulus(0, 1, 64'h8000_0100, 0, 32'd0);
    checkOutput("redir_instr_valid", 64'(instr_valid), 64'd0);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("drop_addr", ireq_addr, 64'h8000_0008);
    checkOutput("drop_req_valid", 64'(ireq_valid), 64'd1);
    checkOutput("drop_wait", 64'(i_wait), 64'd1);
    applyStimulus(0, 0, 64'd0, 1, 32'hDEAD_BEEF);
    checkOutput("drop_discard", 64'(instr_valid), 64'd0);
    checkOutput("drop_addr_kept", ireq_addr, 64'h8000_0008);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("after_drop_addr", ireq_addr, 64'h8000_0100);

    // Redirect to a misaligned target in the same cycle as data_ok.
    applyStimulus(0, 1, 64'h8000_0102, 1, 32'h1111_1111);
    checkOutput("redir_dok_valid", 64'(instr_valid), 64'd0);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("aligned_redir_addr", ireq_addr, 64'h8000_0100);

    // Two redirects during one DROP: the last one wins.
    applyStimulus(0, 1, 64'h8000_0200, 0, 32'd0);
    applyStimulus(0, 1, 64'h8000_0300, 0, 32'd0);
    checkOutput("drop2_addr", ireq_addr, 64'h8000_0100);
    applyStimulus(0, 0, 64'd0, 1, 32'd0);
    checkOutput("drop2_wait", 64'(i_wait), 64'd1);
    applyStimulus(0, 0, 64'd0, 1, 32'h0000_0033);
    checkOutput("last_redir_addr", ireq_addr, 64'h8000_0300);
    checkOutput("last_redir_pc_out", pc_out, 64'h8000_0300);
    checkOutput("last_redir_valid", 64'(instr_valid), 64'd1);

    // Redirect while in HOLD: the buffered word is discarded.
    applyStimulus(1, 0, 64'd0, 1, 32'h0000_0055);
    applyStimulus(1, 1, 64'h8000_0400, 0, 32'd0);
    checkOutput("hold_redir_valid", 64'(instr_valid), 64'd0);
    applyStimulus(0, 0, 64'd0, 0, 32'd0);
    checkOutput("hold_redir_addr", ireq_addr, 64'h8000_0400);
    checkOutput("hold_redir_req", 64'(ireq_valid), 64'd1);

    // Pulse reset while in HOLD.
    applyStimulus(1, 0, 64'd0, 1, 32'h0000_0077);
    applyStimulus(1, 0, 64'd0, 0, 32'd0);
    resetn = 1'b0;
    #1;
    checkOutput("rst_hold_req", 64'(ireq_valid), 64'd0);
    checkOutput("rst_hold_valid", 64'(instr_valid), 64'd0);
    checkOutput("rst_hold_wait", 64'(i_wait), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    stallF = 1'b0;
    #1;
    checkOutput("refetch_valid", 64'(ireq_valid), 64'd1);
    checkOutput("refetch_addr", ireq_addr, 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
